// File: rtl/thermo_pkg.sv
// thermo_pkg: shared encodings and defaults for the thermometer datapath
package thermo_pkg;
  localparam int DEF_DATA_W = 8;
  typedef enum logic [1:0] {DISP_CUR = 2'b00, DISP_AVG = 2'b01, DISP_MAX = 2'b10, DISP_MIN = 2'b11} disp_e;
  typedef enum logic [1:0] {IDLE, READ_OLD, UPDATE, DIVIDE} state_e;
endpackage

// File: rtl/seq_divider.sv
// seq_divider: restoring unsigned divider, one quotient bit per cycle, start/done handshake
module seq_divider #(
  parameter int N = 12,
  parameter int D = 5,
  parameter int Q = N
) (
  input  logic         clk_i,
  input  logic         abort_i,
  input  logic         start_i,
  input  logic [N-1:0] dividend_i,
  input  logic [D-1:0] divisor_i,
  output logic [Q-1:0] quotient_o,
  output logic         done_o
);
  localparam int NW = $clog2(N);
  logic [D-1:0] a_q, a_d, d_q, src_a, src_d;
  logic [N-1:0] q_q, q_d, src_q;
  logic [D:0] sh, diff;
  logic [NW-1:0] n_q;
  logic busy_q, done_q, ge;
  assign quotient_o = q_q[Q-1:0];
  assign done_o = done_q;
  // one restoring step; the start cycle performs the first step so done lands N cycles after start
  always_comb begin
    src_a = start_i ? '0 : a_q;
    src_q = start_i ? dividend_i : q_q;
    src_d = start_i ? divisor_i : d_q;
    sh = {src_a, src_q[N-1]};
    diff = sh - {1'b0, src_d};
    ge = ~diff[D];
    a_d = ge ? diff[D-1:0] : sh[D-1:0];
    q_d = {src_q[N-2:0], ge};
  end
  // load on start, iterate while busy, pulse done after the last step
  always_ff @(posedge clk_i)
    if (abort_i) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= busy_q && !start_i && n_q == NW'(1);
      busy_q <= start_i || (busy_q && n_q != NW'(1));
      if (start_i || busy_q) begin
        a_q <= a_d;
        q_q <= q_d;
      end
      if (start_i) begin
        d_q <= divisor_i;
        n_q <= NW'(N - 1);
      end else if (busy_q)
        n_q <= n_q - NW'(1);
    end
endmodule

// File: rtl/temp_stats_logger.sv
// temp_stats_logger: periodic temperature history with windowed average, max/min and display mux
module temp_stats_logger
  import thermo_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int DEPTH      = 16,
  parameter int SAMPLE_DIV = 100_000_000
) (
  input  logic                     CLK100MHZ,
  input  logic                     CPU_RESETN,
  input  logic [DATA_W-1:0]        temp_in,
  input  logic                     clear,
  input  logic [1:0]               mode_sel,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [DATA_W-1:0]        rd_data,
  output logic [DATA_W-1:0]        disp_data,
  output logic [DATA_W-1:0]        avg_temp,
  output logic [DATA_W-1:0]        max_temp,
  output logic [DATA_W-1:0]        min_temp,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     buf_full,
  output logic                     stats_valid
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int SUM_W  = DATA_W + ADDR_W;
  localparam int CNT_W  = $clog2(SAMPLE_DIV);
  state_e state_q, state_d;
  logic [CNT_W-1:0] div_q;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic [ADDR_W:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] max_q, max_d, min_q, min_d, new_q, new_d, old_q, avg_q, avg_d, disp_q, disp_d, rd_q, quo;
  logic valid_q, valid_d, tick, full, abort, done;
  logic [DATA_W-1:0] mem [DEPTH];
  assign abort = clear | ~CPU_RESETN;
  assign tick = div_q == CNT_W'(SAMPLE_DIV - 1);
  assign full = cnt_q == (ADDR_W + 1)'(DEPTH);
  assign rd_data = rd_q;
  assign disp_data = disp_q;
  assign avg_temp = avg_q;
  assign max_temp = max_q;
  assign min_temp = cnt_q == '0 ? '0 : min_q;
  assign count = cnt_q;
  assign buf_full = full;
  assign stats_valid = valid_q;
  assign disp_d = mode_sel == DISP_CUR ? temp_in : mode_sel == DISP_AVG ? avg_temp : mode_sel == DISP_MAX ? max_temp : min_temp;
  // free-running sample timer, restarted by reset or clear
  always_ff @(posedge CLK100MHZ)
    div_q <= abort || tick ? '0 : div_q + CNT_W'(1);
  // one sample per tick: capture, fetch evicted slot, update window, then divide
  always_comb begin
    state_d = state_q;
    new_d = new_q;
    ptr_d = ptr_q;
    sum_d = sum_q;
    cnt_d = cnt_q;
    max_d = max_q;
    min_d = min_q;
    avg_d = avg_q;
    valid_d = 1'b0;
    case (state_q)
      IDLE: if (tick) begin
        new_d = temp_in;
        state_d = READ_OLD;
      end
      READ_OLD: state_d = UPDATE;
      UPDATE: begin
        ptr_d = ptr_q + ADDR_W'(1);
        cnt_d = full ? cnt_q : cnt_q + (ADDR_W + 1)'(1);
        sum_d = (full ? sum_q - SUM_W'(old_q) : sum_q) + SUM_W'(new_q);
        max_d = new_q > max_q ? new_q : max_q;
        min_d = new_q < min_q ? new_q : min_q;
        state_d = DIVIDE;
      end
      DIVIDE: if (done) begin
        avg_d = quo;
        valid_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // FSM and statistics registers; clear behaves exactly like reset here
  always_ff @(posedge CLK100MHZ)
    if (abort) begin
      state_q <= IDLE;
      new_q <= '0;
      ptr_q <= '0;
      sum_q <= '0;
      cnt_q <= '0;
      max_q <= '0;
      min_q <= '1;
      avg_q <= '0;
      valid_q <= 1'b0;
      disp_q <= '0;
    end else begin
      state_q <= state_d;
      new_q <= new_d;
      ptr_q <= ptr_d;
      sum_q <= sum_d;
      cnt_q <= cnt_d;
      max_q <= max_d;
      min_q <= min_d;
      avg_q <= avg_d;
      valid_q <= valid_d;
      disp_q <= disp_d;
    end
  // port A: read-first, the evicted value is fetched while the new sample waits for UPDATE
  always_ff @(posedge CLK100MHZ) begin
    if (state_q == UPDATE && !abort) mem[ptr_q] <= new_q;
    old_q <= mem[ptr_q];
  end
  // port B readback, independent of the FSM
  always_ff @(posedge CLK100MHZ)
    rd_q <= CPU_RESETN ? mem[rd_addr] : '0;
  seq_divider #(.N(SUM_W), .D(ADDR_W + 1), .Q(DATA_W)) u_div (
    .clk_i(CLK100MHZ),
    .abort_i(abort),
    .start_i(state_q == UPDATE),
    .dividend_i(sum_d),
    .divisor_i(cnt_d),
    .quotient_o(quo),
    .done_o(done)
  );
endmodule

// File: tb/tb_temp_stats_logger.sv
// tb_temp_stats_logger: randomized self-checking bench against a sample-window reference model
module tb_temp_stats_logger;
  localparam int DATA_W = 8;
  localparam int DEPTH = 4;
  localparam int SAMPLE_DIV = 16;
  localparam int ADDR_W = 2;
  localparam int SUM_W = DATA_W + ADDR_W;
  logic CLK100MHZ = 0;
  logic CPU_RESETN = 0;
  logic clear = 0;
  logic [DATA_W-1:0] temp_in = 0;
  logic [1:0] mode_sel = 0;
  logic [ADDR_W-1:0] rd_addr = 0;
  logic [DATA_W-1:0] rd_data, disp_data, avg_temp, max_temp, min_temp;
  logic [ADDR_W:0] count;
  logic buf_full, stats_valid;
  int n_chk = 0;
  int n_fail = 0;
  int ec = 0;
  int base = 0;
  int nk = 0;
  int win[$];
  int ring[DEPTH];
  bit written[DEPTH];
  int wp = 0;
  int mx = 0;
  int mn = 255;

  temp_stats_logger #(.DATA_W(DATA_W), .DEPTH(DEPTH), .SAMPLE_DIV(SAMPLE_DIV)) dut (
    .CLK100MHZ(CLK100MHZ),
    .CPU_RESETN(CPU_RESETN),
    .temp_in(temp_in),
    .clear(clear),
    .mode_sel(mode_sel),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .disp_data(disp_data),
    .avg_temp(avg_temp),
    .max_temp(max_temp),
    .min_temp(min_temp),
    .count(count),
    .buf_full(buf_full),
    .stats_valid(stats_valid)
  );

  always #5 CLK100MHZ = ~CLK100MHZ;
  always @(posedge CLK100MHZ) ec <= ec + 1;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int m_avg();
    int s = 0;
    foreach (win[i]) s += win[i];
    return win.size() > 0 ? s / win.size() : 0;
  endfunction
  function automatic int m_max();
    return win.size() > 0 ? mx : 0;
  endfunction
  function automatic int m_min();
    return win.size() > 0 ? mn : 0;
  endfunction

  task automatic model_clear();
    win.delete();
    wp = 0;
    nk = 0;
    mx = 0;
    mn = 255;
  endtask

  task automatic model_push(input int v);
    win.push_back(v);
    if (win.size() > DEPTH) void'(win.pop_front());
    ring[wp] = v;
    written[wp] = 1;
    wp = (wp + 1) % DEPTH;
    if (v > mx) mx = v;
    if (v < mn) mn = v;
  endtask

  task automatic check_stats(input string tag);
    check({tag, "_count"}, int'(count), win.size());
    check({tag, "_avg"}, int'(avg_temp), m_avg());
    check({tag, "_max"}, int'(max_temp), m_max());
    check({tag, "_min"}, int'(min_temp), m_min());
    check({tag, "_full"}, int'(buf_full), int'(win.size() == DEPTH));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_rd"}, int'(rd_data), 0);
    check({tag, "_disp"}, int'(disp_data), 0);
    check({tag, "_avg"}, int'(avg_temp), 0);
    check({tag, "_max"}, int'(max_temp), 0);
    check({tag, "_min"}, int'(min_temp), 0);
    check({tag, "_count"}, int'(count), 0);
    check({tag, "_full"}, int'(buf_full), 0);
    check({tag, "_valid"}, int'(stats_valid), 0);
  endtask

  task automatic wait_ec(input int t);
    while (ec < t) @(negedge CLK100MHZ);
  endtask

  task automatic sample(input int v, input string tag);
    bit got = 0;
    temp_in = DATA_W'(v);
    for (int i = 0; i < 4 * SAMPLE_DIV && !got; i++) begin
      @(negedge CLK100MHZ);
      got = stats_valid;
    end
    check({tag, "_valid"}, int'(got), 1);
    check({tag, "_latency"}, ec - base, SAMPLE_DIV * (nk + 1) + 3 + SUM_W - 1);
    model_push(v);
    nk++;
    check_stats(tag);
  endtask

  task automatic do_clear();
    clear = 1;
    @(posedge CLK100MHZ);
    @(negedge CLK100MHZ);
    clear = 0;
    base = ec;
    model_clear();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1);
  end

  initial begin
    int r, a, m, e;
    model_clear();
    repeat (3) @(negedge CLK100MHZ);
    check_zero("reset");
    CPU_RESETN = 1;
    base = ec;
    sample(70, "s1a");
    sample(71, "s1b");
    sample(73, "s1c");
    check("s1_avg_const", int'(avg_temp), 71);
    check("s1_min_const", int'(min_temp), 70);
    sample(76, "s2a");
    check("s2a_avg_const", int'(avg_temp), 72);
    check("s2a_full_const", int'(buf_full), 1);
    sample(80, "s2b");
    check("s2b_avg_const", int'(avg_temp), 75);
    check("s2b_max_const", int'(max_temp), 80);
    temp_in = 82;
    for (int i = 0; i < 4; i++) begin
      rd_addr = ADDR_W'(i);
      mode_sel = 2'(i);
      @(negedge CLK100MHZ);
      check("s6_rd", int'(rd_data), ring[i]);
      e = i == 0 ? 82 : i == 1 ? m_avg() : i == 2 ? m_max() : m_min();
      check("s5_disp", int'(disp_data), e);
    end
    check("s6_rd3_const", int'(rd_data), 76);
    check("s5_disp3_const", int'(disp_data), 70);
    sample(82, "s5b");
    temp_in = 90;
    wait_ec(base + SAMPLE_DIV * (nk + 1) + 5);
    model_push(90);
    do_clear();
    check_stats("s3_clr");
    check("s3_clr_valid", int'(stats_valid), 0);
    sample(60, "s3b");
    check("s3b_avg_const", int'(avg_temp), 60);
    check("s3b_count_const", int'(count), 1);
    wait_ec(base + SAMPLE_DIV * (nk + 1) - 1);
    temp_in = 99;
    do_clear();
    check_stats("s4_clr");
    sample(65, "s4b");
    wait_ec(base + SAMPLE_DIV * (nk + 1));
    CPU_RESETN = 0;
    @(negedge CLK100MHZ);
    check_zero("s5_rst");
    CPU_RESETN = 1;
    base = ec;
    model_clear();
    for (int k = 0; k < 24; k++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0) begin
        do_clear();
        check_stats("r_clr");
      end else begin
        sample(int'($urandom_range(0, 255)), "r");
        if (r < 5) begin
          a = int'($urandom_range(0, DEPTH - 1));
          m = int'($urandom_range(0, 3));
          rd_addr = ADDR_W'(a);
          mode_sel = 2'(m);
          @(negedge CLK100MHZ);
          if (written[a]) check("r_rd", int'(rd_data), ring[a]);
          e = m == 0 ? int'(temp_in) : m == 1 ? m_avg() : m == 2 ? m_max() : m_min();
          check("r_disp", int'(disp_data), e);
        end
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
